ram4k_arbiter: RTL and testbench
================================

// Module: ram4k_arbiter
// PURPOSE
//  Shares one RAM4K (4096 x 16, write on clk edge when load=1, out = combinational read of address)
//  between two requesters, A (CPU data port) and B (DMA/peripheral port), with round-robin
//  arbitration. Includes a built-in clear sequencer that writes CLR_VALUE to every word.
//  Sits between the requesters and the RAM4K instance; it is the only driver of the RAM's in/load/address.
// PARAMETERS
//  ADDR_W     12       RAM address width (4096 words)
//  DATA_W     16       RAM data width
//  CLR_VALUE  16'h0000 value written to every word by the clear sequencer
// PORTS
//  clk          in   1       system clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high reset
//  a_req        in   1       A requests an access this cycle
//  a_we         in   1       A access is a write (1) or read (0)
//  a_addr       in   ADDR_W  A word address
//  a_wdata      in   DATA_W  A write data
//  a_gnt        out  1       A access is performed this cycle (combinational)
//  a_rvalid     out  1       a_rdata holds result of A read granted last cycle
//  a_rdata      out  DATA_W  registered read data for A
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid/b_rdata   same as A, for requester B
//  clr_start    in   1       start clear sweep (sampled on clk edge)
//  clr_busy     out  1       clear sweep in progress; all requests stalled
//  clr_done     out  1       one-cycle pulse when sweep completes
//  ram_in       out  DATA_W  to RAM4K in
//  ram_load     out  1       to RAM4K load
//  ram_address  out  ADDR_W  to RAM4K address
//  ram_out      in   DATA_W  from RAM4K out
// BEHAVIOUR
//  Reset (reset=1 at edge): FSM=IDLE, last_gnt=B (so A wins first tie), clr_cnt=0,
//   a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, clr_busy=0, clr_done=0. While reset=1, gnts=0 and ram_load=0.
//  FSM states: IDLE (arbitrate requesters), CLEAR (sweep). IDLE->CLEAR when clr_start=1 at edge;
//   CLEAR->IDLE at edge after address 4095 is written. clr_start in CLEAR is ignored.
//  IDLE arbitration (combinational, same cycle as req):
//   - only one req high -> that requester granted.
//   - both high -> grant the one NOT in last_gnt; last_gnt updates at edge to the granted side.
//   - neither high -> no grant, last_gnt holds, ram_load=0.
//   - ram_address/ram_in = granted side's addr/wdata; ram_load = granted side's we.
//   - ungranted requester must hold req/we/addr/wdata stable until its gnt is seen.
//  Reads: 1-cycle latency. Granted read at cycle N -> x_rdata = ram_out captured at edge ending N,
//   x_rvalid=1 in cycle N+1 only (pulse per read). Writes produce no rvalid. rdata holds until next read.
//  Write then read same address on consecutive cycles returns new data (RAM writes at edge).
//  clr_start cycle itself still arbitrates normally; CLEAR begins next cycle.
//  CLEAR: gnts=0, ram_load=1, ram_in=CLR_VALUE, ram_address=clr_cnt; clr_cnt 0..4095, +1 per cycle,
//   4096 cycles total. clr_busy=1 exactly during CLEAR cycles. clr_done=1 in the first IDLE cycle
//   after the sweep (registered); clr_busy=0 in that cycle. clr_cnt returns to 0.
//  Reset during CLEAR: sweep aborts immediately, memory partially cleared, clr_done not pulsed.
//  last_gnt is not altered by CLEAR; rvalid/rdata outputs hold 0/last value during CLEAR.
// TESTING
//  1. A write 0x1234 @0x005, next cycle A read @0x005 -> a_gnt both cycles, a_rvalid next cycle, a_rdata=0x1234.
//  2. A and B both req continuously (reads @0x010/@0x020) after reset -> grants alternate A,B,A,B...
//  3. Only B reqs for 5 cycles -> b_gnt=1 each cycle; then both req -> A granted first (last_gnt=B).
//  4. Fill 0xFFFF at 0x000,0x7FF,0xFFF; pulse clr_start -> clr_busy high exactly 4096 cycles, gnts 0,
//     clr_done one pulse; reads of those addresses return 0x0000.
//  5. clr_start, reset at sweep cycle 100 -> busy drops next cycle, no clr_done; addr 0x063 reads 0, addr 0x0C8 keeps old data.
//  6. reset held with a_req=1,a_we=1 -> ram_load=0, a_gnt=0, memory unchanged.

Source files
------------

// File: rtl/ram4k_arbiter.sv
// Round-robin arbiter sharing one RAM4K between requesters A and B, with a built-in
// clear sequencer that sweeps CLR_VALUE over every word.
module ram4k_arbiter #(
    parameter int unsigned        ADDR_W    = 12,
    parameter int unsigned        DATA_W    = 16,
    parameter logic [DATA_W-1:0]  CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,

    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic LastA = 1'b0;
    localparam logic LastB = 1'b1;

    state_e              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_done_q, clr_done_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                a_win, b_win;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        clr_cnt_d   = clr_cnt_q;
        clr_done_d  = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_win       = 1'b0;
        b_win       = 1'b0;
        ram_load    = 1'b0;
        ram_in      = '0;
        ram_address = '0;

        // Reset gates every RAM-side strobe so nothing is written while it is held.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    a_win = a_req && (!b_req || (last_gnt_q == LastB));
                    b_win = b_req && !a_win;
                    if (a_win) begin
                        ram_address = a_addr;
                        ram_in      = a_wdata;
                        ram_load    = a_we;
                        last_gnt_d  = LastA;
                        a_rvalid_d  = !a_we;
                        if (!a_we) begin
                            a_rdata_d = ram_out;
                        end
                    end else if (b_win) begin
                        ram_address = b_addr;
                        ram_in      = b_wdata;
                        ram_load    = b_we;
                        last_gnt_d  = LastB;
                        b_rvalid_d  = !b_we;
                        if (!b_we) begin
                            b_rdata_d = ram_out;
                        end
                    end
                    if (clr_start) begin
                        state_d   = StClear;
                        clr_cnt_d = '0;
                    end
                end
                StClear: begin
                    ram_load    = 1'b1;
                    ram_in      = CLR_VALUE;
                    ram_address = clr_cnt_q;
                    if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                        state_d    = StIdle;
                        clr_cnt_d  = '0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_gnt_q <= LastB;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt    = a_win;
    assign b_gnt    = b_win;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign clr_busy = (state_q == StClear);
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Bench for ram4k_arbiter: behavioural RAM4K, shadow memory plus arbitration model,
// and per-requester read-data queues compared when rvalid pulses.
module tb_ram4k_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        clr_start, clr_busy, clr_done;
    logic [15:0] ram_in, ram_out;
    logic        ram_load;
    logic [11:0] ram_address;

    logic [15:0] mem    [4096];
    logic [15:0] shadow [4096];
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    logic        tb_last;
    logic        last_ea, last_eb;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    ram4k_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
    );

    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [11:0] aa,
                         input logic [15:0] ad, input logic br, input logic bw,
                         input logic [11:0] ba, input logic [15:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    // One idle-mode cycle: entered and left at negedge.
    task automatic cycle();
        logic ea, eb, npa, npb;
        #1;
        if (reset) begin
            ea = 1'b0; eb = 1'b0;
        end else begin
            ea = a_req && (!b_req || tb_last);
            eb = b_req && !ea;
        end
        check_eq("a_gnt", a_gnt, ea);
        check_eq("b_gnt", b_gnt, eb);
        check_eq("ram_load", ram_load, (ea && a_we) || (eb && b_we));
        if (ea) check_eq("ram_addr_a", ram_address, a_addr);
        if (eb) check_eq("ram_addr_b", ram_address, b_addr);
        if (ea && a_we) check_eq("ram_in_a", ram_in, a_wdata);
        if (eb && b_we) check_eq("ram_in_b", ram_in, b_wdata);
        npa = ea && !a_we;
        npb = eb && !b_we;
        if (ea) begin
            if (a_we) shadow[a_addr] = a_wdata; else qa.push_back(shadow[a_addr]);
            tb_last = 1'b0;
        end
        if (eb) begin
            if (b_we) shadow[b_addr] = b_wdata; else qb.push_back(shadow[b_addr]);
            tb_last = 1'b1;
        end
        if (reset) begin
            tb_last = 1'b1;
            qa.delete();
            qb.delete();
        end
        last_ea = ea;
        last_eb = eb;
        @(posedge clk);
        #1;
        check_eq("a_rvalid", a_rvalid, npa);
        check_eq("b_rvalid", b_rvalid, npb);
        if (npa) begin
            if (qa.size() > 0) check_eq("a_rdata", a_rdata, qa.pop_front());
            else check_eq("a_queue", 0, 1);
        end
        if (npb) begin
            if (qb.size() > 0) check_eq("b_rdata", b_rdata, qb.pop_front());
            else check_eq("b_queue", 0, 1);
        end
        @(negedge clk);
    endtask

    // Clear sweep; abort_at >= 0 asserts reset during that sweep cycle.
    task automatic sweep(input int abort_at);
        int busy_cycles, bad_cyc, done_seen;
        busy_cycles = 0; bad_cyc = 0; done_seen = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            reset = (k == abort_at);
            #1;
            if (!clr_busy) break;
            busy_cycles++;
            if (a_gnt || b_gnt) bad_cyc++;
            if (reset) begin
                if (ram_load) bad_cyc++;
            end else begin
                if (!ram_load || ram_address != k[11:0] || ram_in != 16'h0000) bad_cyc++;
                shadow[k[11:0]] = 16'h0000;
            end
            if (clr_done) done_seen++;
            @(posedge clk);
            @(negedge clk);
        end
        if (abort_at >= 0) tb_last = 1'b1;
        check_eq("busy_cycles", busy_cycles, (abort_at < 0) ? 4096 : abort_at + 1);
        check_eq("sweep_bad_cycles", bad_cyc, 0);
        check_eq("done_while_busy", done_seen, 0);
        check_eq("clr_done_pulse", clr_done, (abort_at < 0) ? 1 : 0);
        @(posedge clk);
        #1;
        check_eq("clr_done_after", clr_done, 0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 16'(i * 7 + 16'h3000);
            shadow[i] = 16'(i * 7 + 16'h3000);
        end
        tb_last = 1'b1;
        reset = 1'b1;
        clr_start = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check_eq("rst_busy", clr_busy, 0);
        check_eq("rst_done", clr_done, 0);
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
        @(negedge clk);

        // Write then read back on consecutive cycles.
        drive(1, 1, 12'h005, 16'h1234, 0, 0, 0, 0); cycle();
        drive(1, 0, 12'h005, 16'h0000, 0, 0, 0, 0); cycle();
        check_eq("t1_rdata", a_rdata, 16'h1234);

        // Both reading continuously: grants alternate.
        drive(1, 0, 12'h010, 0, 1, 0, 12'h020, 0);
        for (int i = 0; i < 6; i++) cycle();

        // B alone, then a tie goes to A.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, i[0], 12'(12'h030 + i), 16'(16'hB000 + i));
            cycle();
        end
        drive(1, 0, 12'h031, 0, 1, 0, 12'h030, 0);
        cycle();
        check_eq("t3_a_first", last_ea, 1);
        cycle();

        // Randomised traffic; a side only changes its request after being granted.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        last_ea = 1'b1; last_eb = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (!a_req || last_ea) begin
                a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
                a_addr = 12'($urandom_range(0, 15)); a_wdata = 16'($urandom);
            end
            if (!b_req || last_eb) begin
                b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
                b_addr = 12'($urandom_range(0, 15)); b_wdata = 16'($urandom);
            end
            cycle();
        end

        // Full clear sweep.
        drive(1, 1, 12'h000, 16'hFFFF, 0, 0, 0, 0); cycle();
        drive(1, 1, 12'h7FF, 16'hFFFF, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 1, 12'hFFF, 16'hFFFF); cycle();
        sweep(-1);
        drive(1, 0, 12'h000, 0, 1, 0, 12'h7FF, 0); cycle(); cycle();
        drive(1, 0, 12'hFFF, 0, 0, 0, 0, 0); cycle();
        check_eq("t4_fff_zero", a_rdata, 16'h0000);

        // Aborted sweep.
        drive(1, 1, 12'h0C8, 16'hBEEF, 0, 0, 0, 0); cycle();
        drive(1, 1, 12'h063, 16'h5555, 0, 0, 0, 0); cycle();
        sweep(100);
        drive(1, 0, 12'h063, 0, 0, 0, 0, 0); cycle();
        check_eq("t5_063_zero", a_rdata, 16'h0000);
        drive(1, 0, 12'h0C8, 0, 0, 0, 0, 0); cycle();
        check_eq("t5_0c8_kept", a_rdata, 16'hBEEF);
        drive(1, 0, 12'h064, 0, 0, 0, 0, 0); cycle();

        // Reset held with a write pending must not touch memory.
        reset = 1'b1;
        drive(1, 1, 12'h0C8, 16'h1111, 0, 0, 0, 0);
        cycle(); cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_eq("t6_a_rdata", a_rdata, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 12'h0C8, 0); cycle();
        check_eq("t6_mem_kept", b_rdata, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
